// File: rtl/sram_mem_controller_pkg.sv
// Shared state encoding and constants for the 32-bit to 2x16-bit SRAM sequencer.
package sram_mem_controller_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int SRAM_DATA_W       = 16;
    localparam int DEFAULT_ADDR_BASE = 1024;

    // Counter width able to hold HALF_CYCLES-1, never narrower than one bit.
    function automatic int timer_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/sram_mem_controller_half_timer.sv
// Down-counter that times one 16-bit SRAM access: load starts a half, expire marks its last cycle.
module sram_half_timer
    import sram_mem_controller_pkg::*;
#(
    parameter int HALF_CYCLES = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic expire,
    output logic one_left
);

    localparam int                CNT_W    = timer_width(HALF_CYCLES);
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(HALF_CYCLES - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= LOAD_VAL;
        end else if (count != '0) begin
            count <= count - CNT_W'(1);
        end
    end

    assign expire   = (count == '0);
    assign one_left = (count == CNT_W'(1));

endmodule

// File: rtl/sram_mem_controller.sv
// Splits one 32-bit load/store into a low and a high 16-bit SRAM access, holding ready low meanwhile.
module sram_mem_controller
    import sram_mem_controller_pkg::*;
#(
    parameter int ADDR_BASE   = DEFAULT_ADDR_BASE,
    parameter int HALF_CYCLES = 3,
    parameter int SRAM_ADDR_W = 18
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   mem_read,
    input  logic                   mem_write,
    input  logic [31:0]            address,
    input  logic [31:0]            write_data,
    output logic [31:0]            read_data,
    output logic                   ready,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    output logic [SRAM_DATA_W-1:0] sram_dq_out,
    input  logic [SRAM_DATA_W-1:0] sram_dq_in,
    output logic                   sram_dq_oe,
    output logic                   sram_we_n
);

    localparam int WORD_W = SRAM_ADDR_W - 1;

    state_t            state;
    logic              is_write;
    logic [WORD_W-1:0] word;
    logic [15:0]       data_hi;

    logic              request;
    logic              accept;
    logic              expire;
    logic              one_left;
    logic              timer_load;
    logic [WORD_W-1:0] req_word;

    assign request    = mem_read | mem_write;
    assign accept     = (state == ST_IDLE) && request;
    assign req_word   = WORD_W'((address - 32'(ADDR_BASE)) >> 2);
    assign timer_load = accept || ((state == ST_LOW) && expire);

    always_comb begin
        ready = 1'b0;
        case (state)
            ST_IDLE: ready = !request;
            ST_DONE: ready = 1'b1;
            default: ready = 1'b0;
        endcase
    end

    sram_half_timer #(
        .HALF_CYCLES (HALF_CYCLES)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load),
        .expire   (expire),
        .one_left (one_left)
    );

    // Bus outputs are registered one cycle ahead: each edge sets up what the next cycle drives.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            is_write    <= 1'b0;
            word        <= '0;
            data_hi     <= '0;
            read_data   <= '0;
            sram_addr   <= '0;
            sram_dq_out <= '0;
            sram_dq_oe  <= 1'b0;
            sram_we_n   <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (request) begin
                        is_write    <= mem_write;
                        word        <= req_word;
                        data_hi     <= write_data[31:16];
                        sram_addr   <= {req_word, 1'b0};
                        sram_dq_out <= write_data[15:0];
                        sram_dq_oe  <= mem_write;
                        sram_we_n   <= !mem_write;
                        state       <= ST_LOW;
                    end
                end
                ST_LOW: begin
                    if (expire) begin
                        if (!is_write) begin
                            read_data[15:0] <= sram_dq_in;
                        end
                        sram_addr   <= {word, 1'b1};
                        sram_dq_out <= data_hi;
                        sram_we_n   <= !is_write;
                        state       <= ST_HIGH;
                    end else begin
                        // Release the strobe for the final cycle so address and data outlive it.
                        sram_we_n <= !(is_write && !one_left);
                    end
                end
                ST_HIGH: begin
                    if (expire) begin
                        if (!is_write) begin
                            read_data[31:16] <= sram_dq_in;
                        end
                        sram_dq_oe <= 1'b0;
                        sram_we_n  <= 1'b1;
                        state      <= ST_DONE;
                    end else begin
                        sram_we_n <= !(is_write && !one_left);
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_mem_controller.sv
// Bench for sram_mem_controller: two instances (HALF_CYCLES 3 and 1) share stimulus and are checked per cycle.
module tb_sram_mem_controller;

    localparam int AW = 18;

    logic        clk        = 1'b0;
    logic        rst        = 1'b0;
    logic        mem_read   = 1'b0;
    logic        mem_write  = 1'b0;
    logic [31:0] address    = '0;
    logic [31:0] write_data = '0;

    logic [31:0]   read_data0, read_data1;
    logic          ready0, ready1;
    logic [AW-1:0] sram_addr0, sram_addr1;
    logic [15:0]   dq_out0, dq_out1, dq_in0, dq_in1;
    logic          dq_oe0, dq_oe1, we_n0, we_n1;

    bit [15:0] sram0 [64];
    bit [15:0] sram1 [64];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    sram_mem_controller #(.ADDR_BASE(1024), .HALF_CYCLES(3), .SRAM_ADDR_W(AW)) dut0 (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
        .address(address), .write_data(write_data), .read_data(read_data0), .ready(ready0),
        .sram_addr(sram_addr0), .sram_dq_out(dq_out0), .sram_dq_in(dq_in0),
        .sram_dq_oe(dq_oe0), .sram_we_n(we_n0)
    );

    sram_mem_controller #(.ADDR_BASE(1024), .HALF_CYCLES(1), .SRAM_ADDR_W(AW)) dut1 (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
        .address(address), .write_data(write_data), .read_data(read_data1), .ready(ready1),
        .sram_addr(sram_addr1), .sram_dq_out(dq_out1), .sram_dq_in(dq_in1),
        .sram_dq_oe(dq_oe1), .sram_we_n(we_n1)
    );

    // Asynchronous-read SRAMs; a write lands at each clock edge while we_n is low.
    assign dq_in0 = sram0[sram_addr0[5:0]];
    assign dq_in1 = sram1[sram_addr1[5:0]];

    always @(posedge clk) begin
        if (!we_n0) sram0[sram_addr0[5:0]] <= dq_out0;
        if (!we_n1) sram1[sram_addr1[5:0]] <= dq_out1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Transaction-level model: k counts cycles since accept (0 = idle, 1..2H = halves, 2H+1 = done).
    localparam int HC [2] = '{3, 1};
    int          k      [2] = '{0, 0};
    bit          op     [2];
    int          wrd    [2];
    logic [31:0] dat    [2];
    logic [31:0] exp_rd [2] = '{32'h0, 32'h0};
    bit   [15:0] mhalf  [2][64];

    always @(negedge clk) begin
        logic          rdy, oe, wen, req;
        logic [31:0]   rd;
        logic [AW-1:0] sa;
        logic [15:0]   dqo;
        req = mem_read | mem_write;
        for (int d = 0; d < 2; d++) begin
            int h, half, pos;
            h   = HC[d];
            rdy = (d == 0) ? ready0 : ready1;
            rd  = (d == 0) ? read_data0 : read_data1;
            sa  = (d == 0) ? sram_addr0 : sram_addr1;
            dqo = (d == 0) ? dq_out0 : dq_out1;
            oe  = (d == 0) ? dq_oe0 : dq_oe1;
            wen = (d == 0) ? we_n0 : we_n1;
            if (!rst) begin
                check($sformatf("d%0d rst ready", d), rdy, !req);
                check($sformatf("d%0d rst we_n", d), wen, 1);
                check($sformatf("d%0d rst oe", d), oe, 0);
                check($sformatf("d%0d rst read_data", d), rd, 0);
                check($sformatf("d%0d rst sram_addr", d), sa, 0);
                check($sformatf("d%0d rst dq_out", d), dqo, 0);
                k[d] = 0;
                exp_rd[d] = 0;
            end else if (k[d] == 0) begin
                check($sformatf("d%0d idle ready", d), rdy, !req);
                check($sformatf("d%0d idle we_n", d), wen, 1);
                check($sformatf("d%0d idle oe", d), oe, 0);
                check($sformatf("d%0d idle read_data", d), rd, exp_rd[d]);
                if (req) begin
                    op[d]  = mem_write;
                    wrd[d] = int'((address - 32'd1024) >> 2);
                    dat[d] = write_data;
                    k[d]   = 1;
                end
            end else if (k[d] <= 2 * h) begin
                half = (k[d] - 1) / h;
                pos  = (k[d] - 1) % h;
                check($sformatf("d%0d busy ready k%0d", d, k[d]), rdy, 0);
                check($sformatf("d%0d sram_addr k%0d", d, k[d]), sa, 32'(2 * wrd[d] + half));
                check($sformatf("d%0d oe k%0d", d, k[d]), oe, op[d]);
                check($sformatf("d%0d we_n k%0d", d, k[d]), wen, !(op[d] && (pos < h - 1 || h == 1)));
                check($sformatf("d%0d read_data k%0d", d, k[d]), rd, exp_rd[d]);
                if (op[d]) begin
                    check($sformatf("d%0d dq_out k%0d", d, k[d]), dqo,
                          half ? dat[d][31:16] : dat[d][15:0]);
                    if (pos == 0) mhalf[d][2 * wrd[d] + half] = half ? dat[d][31:16] : dat[d][15:0];
                end else if (pos == h - 1) begin
                    if (half == 0) exp_rd[d][15:0]  = mhalf[d][2 * wrd[d]];
                    else           exp_rd[d][31:16] = mhalf[d][2 * wrd[d] + 1];
                end
                k[d]++;
            end else begin
                check($sformatf("d%0d done ready", d), rdy, 1);
                check($sformatf("d%0d done we_n", d), wen, 1);
                check($sformatf("d%0d done oe", d), oe, 0);
                check($sformatf("d%0d done read_data", d), rd, exp_rd[d]);
                k[d] = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] wd);
        mem_read   = rd;
        mem_write  = wr;
        address    = a;
        write_data = wd;
    endtask

    initial begin
        repeat (3) tick();
        @(negedge clk);
        check("reset ready", ready0, 1);
        check("reset we_n", we_n0, 1);
        check("reset read_data", read_data0, 0);
        tick();
        mem_read = 1'b1;
        @(negedge clk);
        check("reset ready with request", ready0, 0);
        tick();
        mem_read = 1'b0;
        rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("idle ready after reset", ready0, 1);
            tick();
        end

        // Store 0xDEADBEEF to word 2: halves 4 (BEEF) then 5 (DEAD).
        drive(0, 1, 32'd1032, 32'hDEADBEEF);
        for (int c = 0; c <= 7; c++) begin
            @(negedge clk);
            check($sformatf("store ready c%0d", c), ready0, c == 7);
            if (c >= 1 && c <= 6) begin
                check($sformatf("store addr c%0d", c), sram_addr0, (c <= 3) ? 32'd4 : 32'd5);
                check($sformatf("store dq c%0d", c), dq_out0, (c <= 3) ? 16'hBEEF : 16'hDEAD);
                check($sformatf("store we_n c%0d", c), we_n0, c == 3 || c == 6);
            end
            if (c == 2) check("h1 store ready c2", ready1, 0);
            if (c == 3) check("h1 store ready c3", ready1, 1);
            tick();
            if (c == 0) drive(0, 0, 0, 0);
        end

        // Load it back, dropping mem_read at cycle 2.
        drive(1, 0, 32'd1032, 32'h0);
        for (int c = 0; c <= 7; c++) begin
            @(negedge clk);
            check($sformatf("load ready c%0d", c), ready0, c == 7);
            if (c == 7) check("load data", read_data0, 32'hDEADBEEF);
            if (c == 3) check("h1 load data", read_data1, 32'hDEADBEEF);
            tick();
            if (c == 1) drive(0, 0, 0, 0);
        end

        // Read and write together: the write wins, read_data unchanged.
        drive(1, 1, 32'd1044, 32'h12345678);
        for (int c = 0; c <= 7; c++) begin
            @(negedge clk);
            if (c == 1) check("rw write strobe", we_n0, 0);
            if (c == 1) check("rw oe", dq_oe0, 1);
            if (c == 7) check("rw read_data kept", read_data0, 32'hDEADBEEF);
            tick();
            if (c == 0) drive(0, 0, 0, 0);
        end
        drive(1, 0, 32'd1044, 32'h0);
        for (int c = 0; c <= 7; c++) begin
            @(negedge clk);
            if (c == 7) check("rw readback", read_data0, 32'h12345678);
            tick();
            if (c == 0) drive(0, 0, 0, 0);
        end

        // Back-to-back store then load with requests held high.
        drive(0, 1, 32'd1060, 32'hCAFEF00D);
        for (int c = 0; c <= 16; c++) begin
            @(negedge clk);
            check($sformatf("b2b ready c%0d", c), ready0, c == 7 || c == 15 || c == 16);
            if (c == 15) check("b2b load data", read_data0, 32'hCAFEF00D);
            tick();
            if (c == 6)  drive(1, 0, 32'd1060, 32'h0);
            if (c == 15) drive(0, 0, 0, 0);
        end

        // Reset in the first high-half cycle of a store leaves only the low half written.
        drive(0, 1, 32'd1064, 32'hAAAA5555);
        for (int c = 0; c <= 5; c++) begin
            @(negedge clk);
            if (c == 4) begin
                check("abort we_n", we_n0, 1);
                check("abort oe", dq_oe0, 0);
                check("abort ready", ready0, 1);
                check("abort read_data", read_data0, 0);
            end
            tick();
            if (c == 0) drive(0, 0, 0, 0);
            if (c == 3) rst = 1'b0;
            if (c == 5) rst = 1'b1;
        end
        tick();
        drive(1, 0, 32'd1064, 32'h0);
        for (int c = 0; c <= 7; c++) begin
            @(negedge clk);
            if (c == 7) check("abort partial word", read_data0, 32'h00005555);
            tick();
            if (c == 0) drive(0, 0, 0, 0);
        end

        // Random traffic, mid-transaction input changes and occasional reset pulses.
        repeat (600) begin
            drive($urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
                  32'd1024 + 32'($urandom_range(0, 127)), $urandom);
            rst = ($urandom_range(0, 63) != 0);
            tick();
        end
        rst = 1'b1;
        drive(0, 0, 0, 0);
        repeat (10) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sram_mem_controller.md
Name: sram_mem_controller

Overview:
- Multi-cycle sequencer between the MEM stage and the off-chip 16-bit SRAM.
- Converts one 32-bit `mem_read`/`mem_write` request, as produced by the control unit and carried down the pipeline, into two 16-bit SRAM accesses.
- Deasserts `ready` for the whole transaction; the hazard/freeze logic uses it to stall every pipeline register.
- Returns the assembled 32-bit load word to the MEM/WB register.

Parameters:
- ADDR_BASE, 1024: byte address of data-memory word 0; subtracted from every request address.
- HALF_CYCLES, 3: clock cycles each 16-bit SRAM access is held; minimum 1.
- SRAM_ADDR_W, 18: SRAM half-word address width.

Ports:
- clk  input  1  system clock, rising-edge active
- rst  input  1  reset, asynchronous, active-low
- mem_read  input  1  load request from MEM stage
- mem_write  input  1  store request from MEM stage
- address  input  32  byte address, word-aligned
- write_data  input  32  store data
- read_data  output  32  load result, valid when ready=1 after a read
- ready  output  1  1 = no transaction in flight; pipeline may advance
- sram_addr  output  SRAM_ADDR_W  SRAM half-word address
- sram_dq_out  output  16  data driven to SRAM
- sram_dq_in  input  16  data returned by SRAM
- sram_dq_oe  output  1  1 = drive sram_dq_out onto bus
- sram_we_n  output  1  SRAM write strobe, active-low

Behaviour:
- Clock and reset:
  - One clock (`clk`). Reset `rst` is asynchronous and active-low.
  - Reset values: state=IDLE, counter=0, read_data=0, sram_addr=0, sram_dq_out=0, sram_dq_oe=0, sram_we_n=1, latched op/addr/data=0.
  - `ready` is combinational, so it is 1 during reset unless a request is present.
- States: IDLE, LOW, HIGH, DONE.
- IDLE:
  - `ready` = !(mem_read | mem_write).
  - On a request, latch op, word index and write_data at the edge, then go to LOW.
  - If mem_read and mem_write are asserted together, the write wins.
- Word index:
  - word = (address - ADDR_BASE) >> 2, truncated to SRAM_ADDR_W-1 bits.
  - Low half address = {word, 1'b0}; high half address = {word, 1'b1}.
  - address[1:0] is ignored.
- LOW:
  - Holds sram_addr at the low half for HALF_CYCLES cycles; the counter runs 0..HALF_CYCLES-1.
  - Write: sram_dq_out=data[15:0], sram_dq_oe=1, sram_we_n=0 for every LOW cycle except the last, where sram_we_n=1. This gives an address/data hold cycle. With HALF_CYCLES=1, sram_we_n=0 for that single cycle.
  - Read: sram_we_n=1, sram_dq_oe=0. Capture sram_dq_in into read_data[15:0] on the last cycle.
  - Counter reaches HALF_CYCLES-1 → clear counter, go to HIGH.
- HIGH:
  - Same sequence at the high half address, using data[31:16] and read_data[31:16].
  - Counter reaches HALF_CYCLES-1 → go to DONE.
- DONE:
  - ready=1 for exactly one cycle; sram_we_n=1, sram_dq_oe=0.
  - Requests are not sampled here. The pipeline advances on this edge, and the next request is accepted from IDLE on the following cycle.
  - Always returns to IDLE.
- Latency: request seen in IDLE at cycle 0 → ready=1 in cycle 2*HALF_CYCLES+1; 7 cycles for the default.
- Inputs are latched at accept. A request that drops or changes mid-transaction is ignored, and the transaction completes unchanged.
- read_data:
  - Holds its value until the next read overwrites it.
  - Writes never modify it.
  - The low half updates before the high half; the full word is consistent only once ready=1.
- Reset asserted mid-transaction:
  - Immediate return to IDLE with reset values.
  - sram_we_n=1 at once.
  - A partially written word is left as-is.

Decomposition:
- Shared defines file:
  - state encodings (2-bit: IDLE=0, LOW=1, HIGH=2, DONE=3)
  - SRAM data width 16
  - default ADDR_BASE
- One sub-module is natural: `sram_half_timer`, a HALF_CYCLES down-counter with load/expire.
- The FSM and datapath stay in the top module.

Test Plan:
- Reset and idle: rst=0 mid-sequence, no request → sram_we_n=1, sram_dq_oe=0, read_data=0, ready=1. Release rst, no request → ready stays 1.
- Single store: mem_write=1, address=1024+8, write_data=32'hDEADBEEF.
  - sram_addr=4 with dq_out=16'hBEEF for 3 cycles, then sram_addr=5 with 16'hDEAD for 3 cycles.
  - we_n low in cycles 1-2 of each half.
  - ready=1 at cycle 7.
- Load after store: mem_read=1 at the same address, SRAM model returning stored data → read_data=32'hDEADBEEF when ready=1, ready=0 in cycles 0-6.
- Back-to-back: store then load with the requests held high.
  - Second transaction starts in the cycle after DONE.
  - Total 16 cycles; no request lost or duplicated.
- Simultaneous mem_read=1 and mem_write=1 → write performed, read_data unchanged.
- Mid-operation:
  - Drop mem_read at cycle 2 → transaction still completes at cycle 7.
  - Assert rst at cycle 4 → state IDLE immediately and sram_we_n=1.
  - Rerun with HALF_CYCLES=1 → ready at cycle 3.
